// File: rtl/controlador_porta.sv
// Door-code entry controller: collects up to six keypad digits, requests one comparison
// per attempt, drives the door-open pulse and enforces a lockout after repeated failures.
module controlador_porta #(
  parameter int unsigned N_DIG      = 6,
  parameter int unsigned T_ABERTA   = 8,
  parameter int unsigned T_BLOQUEIO = 16,
  parameter int unsigned T_INATIVO  = 32,
  parameter int unsigned MAX_FALHAS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] tecla,
  input  logic       tecla_valida,
  input  logic       confirmar,
  input  logic       apagar,
  input  logic       porta_cmp,
  output logic [3:0] m0,
  output logic [3:0] m1,
  output logic [3:0] m2,
  output logic [3:0] m3,
  output logic [3:0] m4,
  output logic [3:0] m5,
  output logic [2:0] d,
  output logic       porta,
  output logic       erro,
  output logic       bloqueado,
  output logic [1:0] falhas
);

  localparam int unsigned TMax12 = (T_ABERTA > T_BLOQUEIO) ? T_ABERTA : T_BLOQUEIO;
  localparam int unsigned TMax   = (TMax12 > T_INATIVO) ? TMax12 : T_INATIVO;
  localparam int unsigned TW     = $clog2(TMax + 1);

  localparam logic [TW-1:0] TAberta     = TW'(T_ABERTA);
  localparam logic [TW-1:0] TBloqueio   = TW'(T_BLOQUEIO);
  localparam logic [TW-1:0] TInativo    = TW'(T_INATIVO);
  localparam logic [TW-1:0] TOne        = TW'(1);
  localparam logic [2:0]    NDig        = 3'(N_DIG);
  localparam logic [1:0]    MaxFalhasM1 = 2'(MAX_FALHAS - 1);

  typedef enum logic [2:0] {
    StInativo,
    StEntrada,
    StVerifica,
    StAberta,
    StBloqueio
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    m_q [6];
  logic [3:0]    m_d [6];
  logic [2:0]    d_q, d_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    falhas_q, falhas_d;
  logic          conf_q, conf_d;
  logic          erro_q, erro_d;
  logic          porta_q, bloq_q;
  logic          digito_ok;

  assign digito_ok = tecla_valida && (tecla <= 4'd9);

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    d_d      = d_q;
    timer_d  = timer_q;
    falhas_d = falhas_q;
    conf_d   = 1'b0;
    erro_d   = 1'b0;
    unique case (state_q)
      StInativo: begin
        if (digito_ok) begin
          m_d[0]  = tecla;
          d_d     = 3'd1;
          timer_d = TInativo;
          state_d = StEntrada;
        end
      end
      StEntrada: begin
        // A submitted attempt waits one cycle with m/d frozen before VERIFICA.
        if (conf_q) begin
          state_d = StVerifica;
        end else if (apagar) begin
          for (int i = 0; i < 6; i++) m_d[i] = 4'd0;
          d_d     = 3'd0;
          timer_d = '0;
          state_d = StInativo;
        end else if (confirmar) begin
          conf_d = 1'b1;
        end else if (digito_ok && (d_q < NDig)) begin
          m_d[d_q] = tecla;
          d_d      = d_q + 3'd1;
          timer_d  = TInativo;
        end else if (timer_q <= TOne) begin
          for (int i = 0; i < 6; i++) m_d[i] = 4'd0;
          d_d     = 3'd0;
          timer_d = '0;
          state_d = StInativo;
        end else begin
          timer_d = timer_q - TOne;
        end
      end
      StVerifica: begin
        for (int i = 0; i < 6; i++) m_d[i] = 4'd0;
        d_d = 3'd0;
        if (porta_cmp) begin
          falhas_d = 2'd0;
          timer_d  = TAberta;
          state_d  = StAberta;
        end else if (falhas_q == MaxFalhasM1) begin
          falhas_d = 2'd0;
          erro_d   = 1'b1;
          timer_d  = TBloqueio;
          state_d  = StBloqueio;
        end else begin
          falhas_d = falhas_q + 2'd1;
          erro_d   = 1'b1;
          timer_d  = '0;
          state_d  = StInativo;
        end
      end
      StAberta, StBloqueio: begin
        if (timer_q <= TOne) begin
          timer_d = '0;
          state_d = StInativo;
        end else begin
          timer_d = timer_q - TOne;
        end
      end
      default: state_d = StInativo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StInativo;
      for (int i = 0; i < 6; i++) m_q[i] <= 4'd0;
      d_q      <= 3'd0;
      timer_q  <= '0;
      falhas_q <= 2'd0;
      conf_q   <= 1'b0;
      erro_q   <= 1'b0;
      porta_q  <= 1'b0;
      bloq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      d_q      <= d_d;
      timer_q  <= timer_d;
      falhas_q <= falhas_d;
      conf_q   <= conf_d;
      erro_q   <= erro_d;
      porta_q  <= (state_d == StAberta);
      bloq_q   <= (state_d == StBloqueio);
    end
  end

  assign m0        = m_q[0];
  assign m1        = m_q[1];
  assign m2        = m_q[2];
  assign m3        = m_q[3];
  assign m4        = m_q[4];
  assign m5        = m_q[5];
  assign d         = d_q;
  assign porta     = porta_q;
  assign erro      = erro_q;
  assign bloqueado = bloq_q;
  assign falhas    = falhas_q;

endmodule
